rsa_cmd_engine: RTL and testbench

Parametrised successor to the single-register ARM↔FPGA command wrapper. It decodes 32-bit ARM commands and holds a bank of `NUM_SLOTS` operand/result registers of `TX_SIZE` bits. It moves data between ARM and any slot, and drives an external arithmetic core (e.g. the Montgomery multiplier) through a start/done handshake. It reports a sticky error flag and the cycle count of the last compute in a status word.

---
 rtl/rsa_cmd_pkg.sv | 31 +++
 rtl/rsa_slot_bank.sv | 45 ++++
 rtl/rsa_cmd_engine.sv | 152 +++++++++++++++
 tb/tb_rsa_cmd_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_cmd_pkg.sv
// rtl/rsa_cmd_pkg.sv - shared encodings for the ARM<->FPGA RSA command engine
package rsa_cmd_pkg;

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_COMPUTE = 4'd1;
  localparam logic [3:0] OP_STORE   = 4'd2;
  localparam logic [3:0] OP_CLR_ERR = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_WRITE     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam int FIELD_W    = 4;
  localparam int CMD_OP_LSB = 0;
  localparam int CMD_F0_LSB = 8;
  localparam int CMD_F1_LSB = 12;
  localparam int CMD_F2_LSB = 16;

  localparam int STAT_ERR_BIT = 31;
  localparam int STAT_CNT_W   = 31;

  function automatic logic slot_ok(input logic [FIELD_W-1:0] idx, input int num_slots);
    return int'(idx) < num_slots;
  endfunction

endpackage

// File: rtl/rsa_slot_bank.sv
// rtl/rsa_slot_bank.sv - operand/result register bank, one write port, three read ports
module rsa_slot_bank
  import rsa_cmd_pkg::*;
#(
  parameter int TX_SIZE   = 1024,
  parameter int NUM_SLOTS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [FIELD_W-1:0] i_widx,
  input  logic [TX_SIZE-1:0] i_wdata,
  input  logic [FIELD_W-1:0] i_ridx0,
  input  logic [FIELD_W-1:0] i_ridx1,
  input  logic [FIELD_W-1:0] i_ridx2,
  output logic [TX_SIZE-1:0] o_rdata0,
  output logic [TX_SIZE-1:0] o_rdata1,
  output logic [TX_SIZE-1:0] o_rdata2
);

  logic [TX_SIZE-1:0] r_mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (reset) begin
        r_mem[i] <= '0;
      end else if (i_we && i_widx == FIELD_W'(i)) begin
        r_mem[i] <= i_wdata;
      end
    end
  end

  // Out-of-range indices read as zero rather than X.
  always_comb begin
    o_rdata0 = '0;
    o_rdata1 = '0;
    o_rdata2 = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i_ridx0 == FIELD_W'(i)) o_rdata0 = r_mem[i];
      if (i_ridx1 == FIELD_W'(i)) o_rdata1 = r_mem[i];
      if (i_ridx2 == FIELD_W'(i)) o_rdata2 = r_mem[i];
    end
  end

endmodule

// File: rtl/rsa_cmd_engine.sv
// rtl/rsa_cmd_engine.sv - command decoder, FSM and compute timer around the slot bank
module rsa_cmd_engine
  import rsa_cmd_pkg::*;
#(
  parameter int TX_SIZE   = 1024,
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        arm_to_fpga_cmd,
  input  logic               arm_to_fpga_cmd_valid,
  output logic               fpga_to_arm_done,
  input  logic               fpga_to_arm_done_read,
  input  logic               arm_to_fpga_data_valid,
  output logic               arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0] arm_to_fpga_data,
  output logic               fpga_to_arm_data_valid,
  input  logic               fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0] fpga_to_arm_data,
  output logic [31:0]        fpga_to_arm_status,
  output logic               core_start,
  output logic [TX_SIZE-1:0] core_a,
  output logic [TX_SIZE-1:0] core_b,
  input  logic               core_done,
  input  logic [TX_SIZE-1:0] core_result,
  output logic [3:0]         leds
);

  localparam logic [STAT_CNT_W-1:0] TIMEOUT_CNT = STAT_CNT_W'(TIMEOUT);

  state_t                  r_state;
  logic [FIELD_W-1:0]      r_f0, r_f1, r_f2;
  logic                    r_err;
  logic [STAT_CNT_W-1:0]   r_last_count;
  logic [STAT_CNT_W-1:0]   r_count;

  logic [FIELD_W-1:0]      w_op, w_f0, w_f1, w_f2;
  logic                    w_illegal;
  logic [STAT_CNT_W-1:0]   w_cnt_next;
  logic                    w_timeout;
  logic                    w_we;
  logic [FIELD_W-1:0]      w_widx;
  logic [TX_SIZE-1:0]      w_wdata;
  logic [TX_SIZE-1:0]      w_unused_rd2;
  logic                    w_unused;

  assign w_op = arm_to_fpga_cmd[CMD_OP_LSB +: FIELD_W];
  assign w_f0 = arm_to_fpga_cmd[CMD_F0_LSB +: FIELD_W];
  assign w_f1 = arm_to_fpga_cmd[CMD_F1_LSB +: FIELD_W];
  assign w_f2 = arm_to_fpga_cmd[CMD_F2_LSB +: FIELD_W];
  assign w_unused = &{1'b0, arm_to_fpga_cmd[7:4], arm_to_fpga_cmd[31:20], w_unused_rd2};

  always_comb begin
    w_illegal = 1'b0;
    case (w_op)
      OP_LOAD, OP_STORE: w_illegal = !slot_ok(w_f0, NUM_SLOTS);
      OP_COMPUTE: w_illegal = !slot_ok(w_f0, NUM_SLOTS) || !slot_ok(w_f1, NUM_SLOTS)
                              || !slot_ok(w_f2, NUM_SLOTS);
      OP_CLR_ERR: w_illegal = 1'b0;
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_cnt_next = (r_count == {STAT_CNT_W{1'b1}}) ? r_count : r_count + 1'b1;
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_f0         <= '0;
      r_f1         <= '0;
      r_f2         <= '0;
      r_err        <= 1'b0;
      r_last_count <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (arm_to_fpga_cmd_valid) begin
          r_f0 <= w_f0;
          r_f1 <= w_f1;
          r_f2 <= w_f2;
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            case (w_op)
              OP_LOAD:    r_state <= ST_READ;
              OP_COMPUTE: r_state <= ST_START;
              OP_STORE:   r_state <= ST_WRITE;
              default: begin
                r_err   <= 1'b0;
                r_state <= ST_DONE;
              end
            endcase
          end
        end
        ST_READ: if (arm_to_fpga_data_valid) r_state <= ST_DONE;
        ST_START: begin
          r_count <= '0;
          r_state <= ST_WAIT_CORE;
        end
        // A core_done on the timeout cycle still counts as success.
        ST_WAIT_CORE: begin
          r_count <= w_cnt_next;
          if (core_done) begin
            r_last_count <= w_cnt_next;
            r_state      <= ST_DONE;
          end else if (w_timeout) begin
            r_err        <= 1'b1;
            r_last_count <= TIMEOUT_CNT;
            r_state      <= ST_DONE;
          end
        end
        ST_WRITE: if (fpga_to_arm_data_ready) r_state <= ST_DONE;
        ST_DONE:  if (fpga_to_arm_done_read) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_we    = (r_state == ST_READ && arm_to_fpga_data_valid) ||
                   (r_state == ST_WAIT_CORE && core_done);
  assign w_widx  = (r_state == ST_READ) ? r_f0 : r_f2;
  assign w_wdata = (r_state == ST_READ) ? arm_to_fpga_data : core_result;

  rsa_slot_bank #(
    .TX_SIZE  (TX_SIZE),
    .NUM_SLOTS(NUM_SLOTS)
  ) u_slot_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_widx  (w_widx),
    .i_wdata (w_wdata),
    .i_ridx0 (r_f0),
    .i_ridx1 (r_f1),
    .i_ridx2 (r_f2),
    .o_rdata0(core_a),
    .o_rdata1(core_b),
    .o_rdata2(w_unused_rd2)
  );

  assign fpga_to_arm_data       = core_a;
  assign arm_to_fpga_data_ready = (r_state == ST_READ);
  assign fpga_to_arm_data_valid = (r_state == ST_WRITE);
  assign core_start             = (r_state == ST_START);
  assign fpga_to_arm_done       = (r_state == ST_DONE);
  assign fpga_to_arm_status     = {r_err, r_last_count};
  assign leds                   = {r_err, r_state};

endmodule

// File: tb/tb_rsa_cmd_engine.sv
// tb/tb_rsa_cmd_engine.sv - directed self-checking bench for rsa_cmd_engine
module tb_rsa_cmd_engine;

  localparam int TX = 64;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [TX-1:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cmd;
  logic          cmd_valid;
  logic          done;
  logic          done_read;
  logic          in_valid;
  logic          in_ready;
  logic [TX-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TX-1:0] out_data;
  logic [31:0]   status;
  logic          core_start;
  logic [TX-1:0] core_a, core_b;
  logic          core_done;
  logic [TX-1:0] core_result = '0;
  logic [3:0]    leds;

  logic core_en = 1'b1;
  logic manual_done = 1'b0;
  logic model_done = 1'b0;
  int   model_cnt = 0;
  int   passed = 0;
  int   total = 0;
  int   n;

  always #5 clk = ~clk;

  rsa_cmd_engine #(.TX_SIZE(TX), .NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .arm_to_fpga_cmd       (cmd),
    .arm_to_fpga_cmd_valid (cmd_valid),
    .fpga_to_arm_done      (done),
    .fpga_to_arm_done_read (done_read),
    .arm_to_fpga_data_valid(in_valid),
    .arm_to_fpga_data_ready(in_ready),
    .arm_to_fpga_data      (in_data),
    .fpga_to_arm_data_valid(out_valid),
    .fpga_to_arm_data_ready(out_ready),
    .fpga_to_arm_data      (out_data),
    .fpga_to_arm_status    (status),
    .core_start            (core_start),
    .core_a                (core_a),
    .core_b                (core_b),
    .core_done             (core_done),
    .core_result           (core_result),
    .leds                  (leds)
  );

  // Core model: done 5 cycles after the start cycle, result = a ^ b.
  assign core_done = model_done | manual_done;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset) begin
      model_cnt <= 0;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) begin
        model_done  <= 1'b1;
        core_result <= core_a ^ core_b;
      end
    end else if (core_start && core_en) begin
      model_cnt <= 4;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic ack;
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] slot, input logic [TX-1:0] d);
    int k = 0;
    in_data = d;
    in_valid = 1'b1;
    send({12'h0, 4'h0, 4'h0, slot, 8'h00});
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    tick();
    in_valid = 1'b0;
    wait_done("load_done");
    ack();
  endtask

  task automatic do_store(input logic [3:0] slot, input logic [TX-1:0] expv, input string tag);
    int k = 0;
    send({12'h0, 4'h0, 4'h0, slot, 8'h02});
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, out_data, expv);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_done("store_done");
    ack();
  endtask

  initial begin
    reset = 1'b1; cmd = '0; cmd_valid = 1'b0; done_read = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_handshakes", 64'({in_ready, out_valid, core_start}), 64'd0);
    chk("rst_core_a", core_a, 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // LOAD slot 2 step by step, holding done until acknowledged
    in_data = PAT_A5;
    send(32'h0000_0200);
    chk("load_read_state", 64'(leds), 64'h1);
    chk("load_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("load_done_next", 64'(done), 64'd1);
    tick(); tick(); tick();
    chk("done_hold", 64'(done), 64'd1);
    ack();
    chk("done_cleared", 64'(done), 64'd0);
    do_store(4'd2, PAT_A5, "store_slot2");

    // cmd_valid during READ is ignored
    in_data = 64'h1;
    send(32'h0000_0000);
    send(32'h0000_0002);
    chk("ignore_cmd_in_read", 64'(leds), 64'h1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("load0_done");
    ack();
    do_load(4'd1, 64'h3);

    // COMPUTE (0,1 -> 3)
    send(32'h0003_1001);
    chk("compute_start", 64'(core_start), 64'd1);
    chk("compute_operands", {core_a[31:0], core_b[31:0]}, {32'h1, 32'h3});
    wait_done("compute_done");
    chk("compute_status", 64'(status), 64'h5);
    ack();
    do_store(4'd3, 64'h2, "store_result3");

    // COMPUTE (0,1 -> 0): destination aliases an operand
    send(32'h0000_1001);
    wait_done("alias_done");
    ack();
    do_store(4'd0, 64'h2, "alias_slot0");
    do_store(4'd1, 64'h3, "alias_slot1");

    // Illegal opcode
    send(32'h0000_0007);
    chk("illegal_op_done", 64'(done), 64'd1);
    chk("illegal_op_status", 64'(status), 64'h8000_0005);
    chk("illegal_op_leds", 64'(leds), 64'hD);
    ack();
    do_store(4'd0, 64'h2, "illegal_slot0");
    do_store(4'd1, 64'h3, "illegal_slot1");
    do_store(4'd2, PAT_A5, "illegal_slot2");
    do_store(4'd3, 64'h2, "illegal_slot3");

    // LOAD with out-of-range slot
    in_data = '1;
    in_valid = 1'b1;
    send(32'h0000_0500);
    in_valid = 1'b0;
    chk("bad_slot_done", 64'(done), 64'd1);
    chk("bad_slot_err", 64'(status[31]), 64'd1);
    ack();
    do_store(4'd1, 64'h3, "bad_slot_slot1");

    // CLR_ERR with done_read already high: DONE lasts one cycle
    done_read = 1'b1;
    send(32'h0000_0003);
    chk("clr_done", 64'(done), 64'd1);
    tick();
    chk("clr_done_one_cycle", 64'(done), 64'd0);
    chk("clr_leds", 64'(leds), 64'h0);
    done_read = 1'b0;
    chk("clr_status", 64'(status), 64'h5);

    // Timeout with a silent core
    core_en = 1'b0;
    send(32'h0003_1001);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd9);
    chk("timeout_status", 64'(status), 64'h8000_0008);
    ack();
    do_store(4'd3, 64'h2, "timeout_slot3");
    send(32'h0000_0003);
    wait_done("clr2_done");
    ack();

    // Reset during WAIT_CORE, then a late core_done
    send(32'h0003_1001);
    tick(); tick();
    chk("wait_state", 64'(leds), 64'h3);
    reset = 1'b1;
    tick();
    chk("reset_to_idle", 64'(leds), 64'h0);
    reset = 1'b0;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    chk("late_done_ignored", 64'(done), 64'd0);
    chk("late_done_idle", 64'(leds), 64'h0);
    chk("reset_status2", 64'(status), 64'd0);
    for (int s = 0; s < NS; s++) do_store(4'(s), 64'd0, "reset_slot_zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
